// File: rtl/turn_pkg.sv
// Shared types and constants for the turn-signal input conditioner.
// Defining FAST_SIM_EN swaps in short debounce/window/divider values for quick simulation.
package turn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPairWait,
    StSingle,
    StBoth
  } turn_state_e;

  typedef enum logic {
    SideL = 1'b0,
    SideR = 1'b1
  } side_e;

`ifdef FAST_SIM_EN
  localparam bit FastSimEn = 1'b1;
`else
  localparam bit FastSimEn = 1'b0;
`endif

  localparam int unsigned FastDebounceCycles = 4;
  localparam int unsigned FastPairWindow     = 8;
  localparam int unsigned FastDiv            = 16;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/turn_debounce.sv
// Two-flop synchronizer followed by a debounce counter: a change is accepted only
// after DEBOUNCE_CYCLES consecutive disagreeing synced samples.
module turn_debounce
  import turn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic debounced
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// Conditions raw left/right switches into clean L/R requests and a periodic Step enable.
// FAST_SIM_EN (see turn_pkg) overrides debounce, pairing window and step divider.
module turn_input_conditioner
  import turn_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned STEP_HZ         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PAIR_WINDOW     = 5000000
) (
  input  logic Clk,
  input  logic Res,
  input  logic L_raw,
  input  logic R_raw,
  output logic L,
  output logic R,
  output logic Step
);

  localparam int unsigned DebEff = FastSimEn ? FastDebounceCycles : DEBOUNCE_CYCLES;
  localparam int unsigned WinEff = FastSimEn ? FastPairWindow : PAIR_WINDOW;
  localparam int unsigned DivEff = FastSimEn ? FastDiv : (CLK_HZ / STEP_HZ);

  localparam int unsigned WinW = cnt_width(WinEff - 1);
  localparam int unsigned DivW = cnt_width(DivEff - 1);
  localparam logic [WinW-1:0] WinMax = WinW'(WinEff - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(DivEff - 1);

  logic deb_l, deb_r;

  turn_debounce #(
    .DEBOUNCE_CYCLES(DebEff)
  ) u_deb_l (
    .clk      (Clk),
    .rst      (Res),
    .raw      (L_raw),
    .debounced(deb_l)
  );

  turn_debounce #(
    .DEBOUNCE_CYCLES(DebEff)
  ) u_deb_r (
    .clk      (Clk),
    .rst      (Res),
    .raw      (R_raw),
    .debounced(deb_r)
  );

  turn_state_e     state_q, state_d;
  side_e           side_q, side_d;
  logic [WinW-1:0] win_q, win_d;
  logic [DivW-1:0] div_q, div_d;
  logic            l_q, l_d, r_q, r_d, step_q, step_d;
  logic            first_on, other_on, enter_hold;

  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    win_d    = win_q;
    first_on = (side_q == SideL) ? deb_l : deb_r;
    other_on = (side_q == SideL) ? deb_r : deb_l;
    unique case (state_q)
      StIdle: begin
        if (deb_l && deb_r) begin
          state_d = StBoth;
        end else if (deb_l ^ deb_r) begin
          state_d = StPairWait;
          side_d  = deb_l ? SideL : SideR;
          win_d   = '0;
        end
      end
      StPairWait: begin
        // A release of the first side wins over a coincident second press.
        if (!first_on) begin
          state_d = StIdle;
        end else if (other_on) begin
          state_d = StBoth;
        end else if (win_q == WinMax) begin
          state_d = StSingle;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      StSingle: begin
        if (!first_on) state_d = StIdle;
      end
      StBoth: begin
        if (!deb_l && !deb_r) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    enter_hold = (state_d != state_q) && ((state_d == StSingle) || (state_d == StBoth));
    step_d     = 1'b0;
    div_d      = div_q + 1'b1;
    if (enter_hold) begin
      div_d = '0;
    end else if (div_q == DivMax) begin
      div_d  = '0;
      step_d = 1'b1;
    end
    l_d = (state_d == StBoth) || ((state_d == StSingle) && (side_d == SideL));
    r_d = (state_d == StBoth) || ((state_d == StSingle) && (side_d == SideR));
  end

  always_ff @(posedge Clk or posedge Res) begin
    if (Res) begin
      state_q <= StIdle;
      side_q  <= SideL;
      win_q   <= '0;
      div_q   <= '0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      win_q   <= win_d;
      div_q   <= div_d;
      l_q     <= l_d;
      r_q     <= r_d;
      step_q  <= step_d;
    end
  end

  assign L    = l_q;
  assign R    = r_q;
  assign Step = step_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner with debounce 4, window 8, step divider 16.
module tb_turn_input_conditioner;

  logic Clk = 1'b0;
  logic Res, L_raw, R_raw;
  logic L, R, Step;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  // Parameters chosen so the effective values match the fast-sim constants either way.
  turn_input_conditioner #(
    .CLK_HZ         (16),
    .STEP_HZ        (1),
    .DEBOUNCE_CYCLES(4),
    .PAIR_WINDOW    (8)
  ) dut (
    .Clk  (Clk),
    .Res  (Res),
    .L_raw(L_raw),
    .R_raw(R_raw),
    .L    (L),
    .R    (R),
    .Step (Step)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_step(input int budget, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!Step && n < budget);
  endtask

  int n, both_at, r_at;
  logic seen, r_alone;

  initial begin
    Res = 1'b1; L_raw = 1'b0; R_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      L_raw = ~L_raw;
      R_raw = i[0];
    end
    check_eq("reset_l", int'(L), 0);
    check_eq("reset_r", int'(R), 0);
    check_eq("reset_step", int'(Step), 0);
    L_raw = 1'b0; R_raw = 1'b0;
    tick(1);
    Res = 1'b0;

    // Step cadence while idle
    wait_step(40, n);
    check_eq("step_sync", int'(Step), 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("step_width", int'(Step), 0);
      wait_step(40, n);
      check_eq("step_period", n + 1, 16);
    end

    // Glitch of 3 cycles must be rejected
    tick(5);
    L_raw = 1'b1;
    tick(3);
    L_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (L || R) seen = 1'b1;
    end
    check_eq("glitch_rejected", int'(seen), 0);

    // Steady left press: PAIR_WAIT then SINGLE after the window
    L_raw = 1'b1;
    tick(14);
    check_eq("single_l_early", int'(L), 0);
    tick(1);
    check_eq("single_l_on", int'(L), 1);
    check_eq("single_r_off", int'(R), 0);
    wait_step(40, n);
    check_eq("single_first_step", n, 16);
    L_raw = 1'b0;
    tick(7);
    check_eq("single_l_release", int'(L), 0);
    tick(20);

    // Right then left 5 cycles later resolves to BOTH
    R_raw = 1'b1; both_at = 0; r_alone = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 5) L_raw = 1'b1;
      if (R && !L) r_alone = 1'b1;
      if (L && R && both_at == 0) both_at = i;
    end
    check_eq("pair_r_alone", int'(r_alone), 0);
    check_eq("pair_both_at", both_at, 12);

    // Releasing one side holds BOTH; releasing the other exits 7 cycles later
    L_raw = 1'b0;
    tick(12);
    check_eq("hold_l", int'(L), 1);
    check_eq("hold_r", int'(R), 1);
    R_raw = 1'b0;
    tick(6);
    check_eq("release_l_pending", int'(L), 1);
    tick(1);
    check_eq("release_l_off", int'(L), 0);
    check_eq("release_r_off", int'(R), 0);
    tick(20);

    // Late second press is ignored once SINGLE is reached
    R_raw = 1'b1; r_at = 0; seen = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 12) L_raw = 1'b1;
      if (L) seen = 1'b1;
      if (R && r_at == 0) r_at = i;
    end
    check_eq("late_r_at", r_at, 15);
    check_eq("late_r_held", int'(R), 1);
    L_raw = 1'b0; R_raw = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (L) seen = 1'b1;
    end
    check_eq("late_l_never", int'(seen), 0);
    check_eq("late_r_off", int'(R), 0);
    tick(20);

    // Asynchronous reset while in BOTH clears outputs without a clock edge
    L_raw = 1'b1; R_raw = 1'b1;
    tick(10);
    check_eq("pre_reset_l", int'(L), 1);
    check_eq("pre_reset_r", int'(R), 1);
    #2 Res = 1'b1;
    #1;
    check_eq("async_l", int'(L), 0);
    check_eq("async_r", int'(R), 0);
    check_eq("async_step", int'(Step), 0);
    L_raw = 1'b0; R_raw = 1'b0;
    tick(2);
    Res = 1'b0;
    tick(10);
    check_eq("post_reset_l", int'(L), 0);
    check_eq("post_reset_r", int'(R), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
